// File: rtl/pifo_req_frontend_pkg.sv
// ---------------------------------------------------------------------------
// pifo_req_frontend_pkg
// Purpose : Shared definitions for the PIFO request front end. It holds the
//           request-entry layout, the op encodings and the default widths.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package pifo_req_frontend_pkg;

  localparam int PTW_DEF   = 8;  // push/pop data width
  localparam int TW_DEF    = 2;  // tree-id width
  localparam int LEVEL_DEF = 4;  // number of client lanes
  localparam int DEPTH_DEF = 4;  // per-lane FIFO entries

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  // Entry layout at the default widths. The FIFO stores entries in the same
  // field order {op, tree_id, data}, packed MSB to LSB.
  typedef struct packed {
    op_e                 op;
    logic [TW_DEF-1:0]   tree_id;
    logic [PTW_DEF-1:0]  data;
  } req_entry_t;

  // Width of a lane index. It is kept at least one bit so that a
  // single-lane build still has a legal port.
  function automatic int lane_w(input int level);
    return (level > 1) ? $clog2(level) : 1;
  endfunction

endpackage

// File: rtl/pifo_req_fifo.sv
// ---------------------------------------------------------------------------
// pifo_req_fifo
// Purpose : One lane's request FIFO. A push and a pop strobe in the same
//           cycle enqueue two entries, push first. Any strobe seen while
//           o_full is high is dropped whole and sets the sticky o_overflow.
// Ports   : i_clk, i_arst_n      clock, async active-low reset
//           i_push, i_pop        lane strobes
//           i_tree_id            target tree for both entries
//           i_push_data          push payload (pop entries carry 0)
//           i_deq                dequeue the head (ignored when empty)
//           o_head               head entry {op, tree_id, data}
//           o_empty              no entries held
//           o_full               registered: fewer than 2 free entries
//           o_overflow           sticky: a request was dropped
// ---------------------------------------------------------------------------
module pifo_req_fifo
  import pifo_req_frontend_pkg::*;
#(
  parameter int PTW   = PTW_DEF,
  parameter int TW    = TW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                i_clk,
  input  logic                i_arst_n,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [TW-1:0]       i_tree_id,
  input  logic [PTW-1:0]      i_push_data,
  input  logic                i_deq,
  output logic [TW+PTW:0]     o_head,
  output logic                o_empty,
  output logic                o_full,
  output logic                o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = 1 + TW + PTW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic          r_overflow;

  logic          w_strobe;
  logic          w_accept;
  logic          w_deq;
  logic [W-1:0]  w_push_entry;
  logic [W-1:0]  w_pop_entry;
  logic [CW-1:0] w_nwr;
  logic [CW-1:0] w_cnt_next;

  assign w_strobe     = i_push | i_pop;
  // Full means fewer than two free slots, so an accepted strobe always
  // has room for both of its entries even with no dequeue this cycle.
  assign w_accept     = w_strobe & ~r_full;
  assign w_deq        = i_deq & (r_cnt != '0);
  assign w_push_entry = {1'(OP_PUSH), i_tree_id, i_push_data};
  assign w_pop_entry  = {1'(OP_POP), i_tree_id, {PTW{1'b0}}};
  assign w_nwr        = w_accept ? (CW'(i_push) + CW'(i_pop)) : '0;
  assign w_cnt_next   = r_cnt + w_nwr - CW'(w_deq);

  // Storage is not reset. Clearing the pointers and the count empties the
  // FIFO, and stale words are never read back.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= w_push_entry;
        if (i_pop) begin
          r_mem[r_wr_ptr + AW'(1)] <= w_pop_entry;
        end
      end else begin
        r_mem[r_wr_ptr] <= w_pop_entry;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_nwr);
      r_rd_ptr <= r_rd_ptr + AW'(w_deq);
      r_cnt    <= w_cnt_next;
      r_full   <= (w_cnt_next > CW'(DEPTH - 2));
      if (w_strobe && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_empty    = (r_cnt == '0);
  assign o_full     = r_full;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/pifo_req_frontend.sv
// ---------------------------------------------------------------------------
// pifo_req_frontend
// Purpose : Collects per-lane push/pop requests into lane FIFOs. A
//           round-robin arbiter issues them one at a time to a PIFO core.
//           Pop responses from the core are routed back to their lanes.
// Ports   : i_clk, i_arst_n            clock, async active-low reset
//           i_push/i_pop [LEVEL]       per-lane strobes
//           i_tree_id [LEVEL*TW]       per-lane target tree
//           i_push_data [LEVEL*PTW]    per-lane push payload
//           o_task_fifo_full [LEVEL]   per-lane backpressure (registered)
//           o_overflow [LEVEL]         sticky per-lane drop flag
//           o_pop_data [LEVEL*PTW]     last popped value per lane
//           o_pop_valid [LEVEL]        one-cycle pulse on o_pop_data update
//           o_core_*/i_core_ready      request channel to the core
//           i_core_rsp_*               pop-response channel from the core
//
// Request channel: a transfer happens on a rising edge where o_core_valid
// and i_core_ready are both high. Once o_core_valid is raised, it and every
// o_core_* field hold steady until that transfer, and the grant is not
// re-arbitrated while it waits.
// ---------------------------------------------------------------------------
module pifo_req_frontend
  import pifo_req_frontend_pkg::*;
#(
  parameter int PTW   = PTW_DEF,
  parameter int LEVEL = LEVEL_DEF,
  parameter int TW    = TW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int LW   = lane_w(LEVEL)
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic [LEVEL-1:0]       i_push,
  input  logic [LEVEL-1:0]       i_pop,
  input  logic [LEVEL*TW-1:0]    i_tree_id,
  input  logic [LEVEL*PTW-1:0]   i_push_data,
  output logic [LEVEL-1:0]       o_task_fifo_full,
  output logic [LEVEL*PTW-1:0]   o_pop_data,
  output logic [LEVEL-1:0]       o_pop_valid,
  output logic [LEVEL-1:0]       o_overflow,
  output logic                   o_core_valid,
  input  logic                   i_core_ready,
  output logic                   o_core_op,
  output logic [TW-1:0]          o_core_tree_id,
  output logic [PTW-1:0]         o_core_data,
  output logic [LW-1:0]          o_core_lane,
  input  logic                   i_core_rsp_valid,
  input  logic [LW-1:0]          i_core_rsp_lane,
  input  logic [PTW-1:0]         i_core_rsp_data
);

  localparam int W = 1 + TW + PTW;

  logic [LEVEL-1:0]     w_empty;
  logic [LEVEL-1:0]     w_deq;
  logic [LEVEL-1:0]     w_full;
  logic [LEVEL-1:0]     w_ovf;
  logic [W-1:0]         w_head [LEVEL];

  logic [LW-1:0]        r_rr;
  logic                 r_lock;       // offer waiting on i_core_ready
  logic [LW-1:0]        r_lock_lane;
  logic [LEVEL-1:0]     r_pop_valid;
  logic [LEVEL*PTW-1:0] r_pop_data;

  logic [LW-1:0]        w_search_lane;
  logic                 w_search_found;
  logic [LW-1:0]        w_grant;
  logic                 w_valid;
  logic                 w_hs;
  logic [W-1:0]         w_sel;

  // ---- lane FIFOs ---------------------------------------------------------
  for (genvar j = 0; j < LEVEL; j++) begin : g_lane
    pifo_req_fifo #(
      .PTW   (PTW),
      .TW    (TW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk       (i_clk),
      .i_arst_n    (i_arst_n),
      .i_push      (i_push[j]),
      .i_pop       (i_pop[j]),
      .i_tree_id   (i_tree_id[j*TW +: TW]),
      .i_push_data (i_push_data[j*PTW +: PTW]),
      .i_deq       (w_deq[j]),
      .o_head      (w_head[j]),
      .o_empty     (w_empty[j]),
      .o_full      (w_full[j]),
      .o_overflow  (w_ovf[j])
    );
    assign w_deq[j] = w_hs & (w_grant == LW'(j));
  end

  assign o_task_fifo_full = w_full;
  assign o_overflow       = w_ovf;

  // ---- round-robin search: first non-empty lane at or after r_rr ----------
  always_comb begin
    int idx;
    idx            = 0;
    w_search_found = 1'b0;
    w_search_lane  = '0;
    for (int i = 0; i < LEVEL; i++) begin
      idx = (int'(r_rr) + i) % LEVEL;
      if (!w_search_found && !w_empty[idx]) begin
        w_search_found = 1'b1;
        w_search_lane  = LW'(idx);
      end
    end
  end

  // A stalled offer keeps its lane. Its FIFO cannot drain meanwhile, so
  // the lane stays non-empty until the transfer.
  assign w_grant = r_lock ? r_lock_lane : w_search_lane;
  assign w_valid = r_lock ? ~w_empty[r_lock_lane] : w_search_found;
  assign w_hs    = w_valid & i_core_ready;
  assign w_sel   = w_head[w_grant];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_rr        <= '0;
      r_lock      <= 1'b0;
      r_lock_lane <= '0;
    end else begin
      r_lock      <= w_valid & ~i_core_ready;
      r_lock_lane <= w_grant;
      if (w_hs) begin
        r_rr <= (w_grant == LW'(LEVEL - 1)) ? '0 : w_grant + LW'(1);
      end
    end
  end

  assign o_core_valid   = w_valid;
  assign o_core_op      = w_valid ? w_sel[W-1] : 1'b0;
  assign o_core_tree_id = w_valid ? w_sel[PTW +: TW] : '0;
  assign o_core_data    = w_valid ? w_sel[PTW-1:0] : '0;
  assign o_core_lane    = w_valid ? w_grant : '0;

  // ---- pop-response routing ----------------------------------------------
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_pop_valid <= '0;
      r_pop_data  <= '0;
    end else begin
      r_pop_valid <= '0;
      if (i_core_rsp_valid && (int'(i_core_rsp_lane) < LEVEL)) begin
        r_pop_valid[i_core_rsp_lane]                   <= 1'b1;
        r_pop_data[int'(i_core_rsp_lane)*PTW +: PTW]   <= i_core_rsp_data;
      end
    end
  end

  assign o_pop_valid = r_pop_valid;
  assign o_pop_data  = r_pop_data;

endmodule
